// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op codes and latencies.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_div_unit_pkg;

  // Operation select codes driven on mult_div_unit.op
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // Cycles from the accepting edge to the edge that writes hi/lo
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  // The counter is loaded with one less than the latency: the final edge
  // is the one where the counter already reads zero.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed at the start edge, released late.
// Latency: mult 5 cycles, div 10 cycles from accepting edge to hi/lo update; mthi/mtlo same edge.
// Backpressure: busy high while a result is pending; start is ignored while busy.
//
// Ports:
//   clk, reset    single clock, synchronous active-high reset
//   A, B          32-bit operands (rs, rt)
//   op            operation select (MD_* codes)
//   start         op/A/B valid this cycle
//   busy          operation in flight
//   hi, lo        architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;          // cleared for divide-by-zero: completion keeps hi/lo
  logic        accept, done, mt_hi, mt_lo;

  // ---------------- result datapath (evaluated every cycle, captured on accept)
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, dvd, dvs, dvs_safe, qu, ru, q_s, r_s;
  logic [31:0] res_hi_d, res_lo_d;
  logic        res_wr_d;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes, then restores signs: quotient truncates
  // toward zero and the remainder follows the dividend. 0x80000000 / -1 falls
  // out naturally as magnitude 0x80000000 with a positive sign.
  assign mag_a    = A[31] ? -A : A;
  assign mag_b    = B[31] ? -B : B;
  assign dvd      = (op == MD_DIV) ? mag_a : A;
  assign dvs      = (op == MD_DIV) ? mag_b : B;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;  // keeps the divider defined
  assign qu       = dvd / dvs_safe;
  assign ru       = dvd % dvs_safe;
  assign q_s      = (A[31] ^ B[31]) ? -qu : qu;
  assign r_s      = A[31] ? -ru : ru;

  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    res_wr_d = 1'b1;
    case (op)
      MD_MULT:  {res_hi_d, res_lo_d} = prod_s;
      MD_MULTU: {res_hi_d, res_lo_d} = prod_u;
      MD_DIV: begin
        res_hi_d = r_s;
        res_lo_d = q_s;
        res_wr_d = (B != 32'd0);
      end
      MD_DIVU: begin
        res_hi_d = ru;
        res_lo_d = qu;
        res_wr_d = (B != 32'd0);
      end
      default: ;
    endcase
  end

  // ---------------- control FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_arith_op(op)) begin
            accept    = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = is_div_op(op) ? DIV_LOAD : MULT_LOAD;
          end else if (op == MD_MTHI) begin
            mt_hi = 1'b1;
          end else if (op == MD_MTLO) begin
            mt_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // ---------------- counter, captured result, architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      cnt <= cnt_nxt;
      if (accept) begin
        res_hi <= res_hi_d;
        res_lo <= res_lo_d;
        res_wr <= res_wr_d;
      end
      if (done && res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (mt_hi) hi <= A;
      if (mt_lo) lo <= A;
    end
  end

endmodule
